mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencer for the memory-side datapath registers (MAR, MDR) and the external memory handshake. On a one-cycle `start` from the control unit it runs a complete load or store: latch the address into MAR, load write data into MDR (stores only), hold the memory strobe until `mem_ready`, capture read data into MDR (loads only), then report `done` or `err`. It sits between the control unit and the MAR/MDR/memory interface. It generates only register enables, the MDR mux select and memory strobes; it never touches data.

## Interface
- `TIMEOUT`, default 16: maximum cycles spent in MEM before aborting; legal range 2..255.
- `clock` in 1: single clock; all state changes on its rising edge.
- `clear_n` in 1: synchronous reset, active-low; sampled on the rising edge of `clock`.
- `start` in 1: transaction request; honoured only in IDLE.
- `rw` in 1: 1 = read (load), 0 = write (store); sampled together with `start`.
- `mem_ready` in 1: memory completion; for reads, `Mdatain` is valid in the same cycle.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse on successful completion.
- `err` out 1: one-cycle pulse on timeout.
- `MARin` out 1: MAR load enable; the address is on the bus in this cycle.
- `MDRin` out 1: MDR load enable.
- `Read` out 1: MDR input select; 1 = `Mdatain`, 0 = `BusMuxOut`.
- `mem_rd` out 1: memory read strobe.
- `mem_wr` out 1: memory write strobe.

## Operation
- States: IDLE, ADDR, WDATA, MEM, DONE, ERR. `rw` is latched into an internal `op_rd` register when `start` is accepted.
- IDLE:
  - All outputs 0.
  - `start`=1 → ADDR; the timeout counter is cleared.
- ADDR:
  - `MARin`=1.
  - Next state is MEM if `op_rd`=1, otherwise WDATA.
- WDATA (writes only):
  - `MDRin`=1, `Read`=0, so MDR captures `BusMuxOut`.
  - Next state is MEM.
- MEM, read:
  - `mem_rd`=1 and `Read`=1 for the whole state.
  - `MDRin` = `mem_ready` (Mealy output), so MDR captures `Mdatain` on the same edge that `mem_ready` is sampled.
  - `mem_ready` → DONE.
- MEM, write:
  - `mem_wr`=1, `MDRin`=0, `Read`=0.
  - `mem_ready` → DONE.
- MEM timeout:
  - The counter increments every MEM cycle without `mem_ready`.
  - If the count reaches `TIMEOUT`-1 with `mem_ready`=0 → ERR.
  - `mem_ready` wins if it coincides with the timeout cycle.
- DONE: `done`=1, then → IDLE.
- ERR:
  - `err`=1, then → IDLE.
  - MDR is not written on timeout.
- `start` outside IDLE, including in DONE and ERR, is ignored and not queued.
- `mem_ready` outside MEM is ignored.
- `mem_rd` and `mem_wr` are never high together.
- `MARin` and `MDRin` are never high together.

## Timing
- Reset:
  - `clear_n`=0 at a rising edge → IDLE, counter 0, `op_rd` 0.
  - All outputs are 0 from the following cycle.
  - This holds mid-transaction: strobes drop immediately after that edge, and no `done` or `err` is issued.
- Outputs are registered-state decodes, except `MDRin` in read MEM, which is combinational on `mem_ready`.
- In the cycle sequences below, `start` is sampled at the end of cycle 0 and N is the number of MEM cycles including the ready cycle (1..`TIMEOUT`).
- Read sequence:
  - ADDR in cycle 1; MEM in cycles 2..N+1; DONE in cycle N+2; IDLE in cycle N+3.
  - Minimum latency from `start` to `done` is 3 cycles.
- Write sequence:
  - ADDR in cycle 1; WDATA in cycle 2; MEM in cycles 3..N+2; DONE in cycle N+3.
  - Minimum latency from `start` to `done` is 4 cycles.
- Timeout:
  - Exactly `TIMEOUT` MEM cycles, then ERR for 1 cycle.
  - The strobe is high for exactly `TIMEOUT` cycles.
- Back-to-back: a new `start` is accepted no earlier than the first IDLE cycle after DONE or ERR.

## Test plan
- Reset, then read with `mem_ready` high in the first MEM cycle, `Mdatain`=0xDEADBEEF:
  - Required sequence: `MARin` in cycle 1; `mem_rd`, `Read` and `MDRin` in cycle 2; `done` in cycle 3; `busy` high in cycles 1–3.
  - MDR then holds 0xDEADBEEF.
- Write with `mem_ready` delayed 3 cycles:
  - `MARin` in cycle 1; `MDRin`=1 with `Read`=0 in cycle 2.
  - `mem_wr` high in cycles 3–6; `done` in cycle 7; `mem_rd` never asserted.
- Timeout with `TIMEOUT`=4 and `mem_ready` held 0:
  - `mem_rd` high for exactly 4 cycles, then `err` for 1 cycle.
  - `MDRin` never asserted; `done` never asserted.
- `mem_ready` arrives in the 4th MEM cycle (the timeout cycle) with `TIMEOUT`=4:
  - `done` is pulsed, not `err`.
- `clear_n` pulled low during write MEM cycle 2:
  - The next cycle has all outputs 0 and IDLE; no `done` or `err`.
  - A new `start` is then accepted normally.
- `start` pulsed while in ADDR, MEM and DONE of an ongoing read:
  - Ignored; exactly one `done` is issued.
  - `start` in the following IDLE cycle launches a second transaction.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MAR/MDR enables and the memory handshake for one load or store
//   clock     in  : single clock, rising edge
//   clear_n   in  : synchronous active-low reset
//   start     in  : transaction request, honoured only in IDLE
//   rw        in  : 1 = read (load), 0 = write (store), sampled with start
//   mem_ready in  : memory completion; read data valid in the same cycle
//   busy      out : state is not IDLE
//   done      out : one-cycle pulse on successful completion
//   err       out : one-cycle pulse on timeout
//   MARin     out : MAR load enable
//   MDRin     out : MDR load enable
//   Read      out : MDR input select, 1 = Mdatain, 0 = BusMuxOut
//   mem_rd    out : memory read strobe
//   mem_wr    out : memory write strobe
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic clear_n,
    input  logic start,
    input  logic rw,
    input  logic mem_ready,
    output logic busy,
    output logic done,
    output logic err,
    output logic MARin,
    output logic MDRin,
    output logic Read,
    output logic mem_rd,
    output logic mem_wr
);
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, MEM, DONE, ERR} state_t;
    state_t     r_state;
    state_t     w_next;
    logic       r_op_rd;
    logic [7:0] r_cnt;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
    logic       r_marin;
    logic       r_mdr_wdata;
    logic       r_mem_rd;
    logic       r_mem_wr;
    logic       w_timeout;

    assign w_timeout = r_cnt == 8'(TIMEOUT - 1);

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = start ? ADDR : IDLE;
            ADDR:    w_next = r_op_rd ? MEM : WDATA;
            WDATA:   w_next = MEM;
            MEM:     w_next = mem_ready ? DONE : (w_timeout ? ERR : MEM);
            default: w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    // r_op_rd is already settled whenever the next state is MEM.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_state     <= IDLE;
            r_op_rd     <= 1'b0;
            r_cnt       <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_marin     <= 1'b0;
            r_mdr_wdata <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_op_rd <= rw;
                r_cnt   <= 8'd0;
            end else if (r_state == MEM && !mem_ready) begin
                r_cnt <= r_cnt + 8'd1;
            end
            r_busy      <= w_next != IDLE;
            r_done      <= w_next == DONE;
            r_err       <= w_next == ERR;
            r_marin     <= w_next == ADDR;
            r_mdr_wdata <= w_next == WDATA;
            r_mem_rd    <= w_next == MEM && r_op_rd;
            r_mem_wr    <= w_next == MEM && !r_op_rd;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign err    = r_err;
    assign MARin  = r_marin;
    // Read MEM captures Mdatain on the same edge mem_ready is sampled.
    assign MDRin  = r_mdr_wdata | (r_mem_rd & mem_ready);
    assign Read   = r_mem_rd;
    assign mem_rd = r_mem_rd;
    assign mem_wr = r_mem_wr;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed-vector bench for mem_access_ctrl with TIMEOUT=4
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic clear_n = 1'b0;
    logic start = 1'b0;
    logic rw = 1'b0;
    logic mem_ready = 1'b0;
    logic busy, done, err, MARin, MDRin, Read, mem_rd, mem_wr;
    logic [31:0] mdatain = 32'h0;
    logic [31:0] bus = 32'h12345678;
    logic [31:0] mdr = 32'h0;
    logic [7:0] o;
    int n_cmp = 0;
    int n_bad = 0;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clock(clk), .clear_n(clear_n), .start(start), .rw(rw), .mem_ready(mem_ready),
        .busy(busy), .done(done), .err(err), .MARin(MARin), .MDRin(MDRin),
        .Read(Read), .mem_rd(mem_rd), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (MDRin) mdr <= Read ? mdatain : bus;

    // v = {clear_n, start, rw, mem_ready}; o = {busy,done,err,MARin,MDRin,Read,mem_rd,mem_wr}
    task automatic step(input logic [3:0] v);
        @(negedge clk);
        {clear_n, start, rw, mem_ready} = v;
        #1;
        o = {busy, done, err, MARin, MDRin, Read, mem_rd, mem_wr};
    endtask

    task automatic test_reset;
        step(4'h0);
        step(4'h0);
        n_cmp++;
        if (o !== 8'h00) begin n_bad++; $display("FAIL reset_hold got %h want 00", o); end
        step(4'h8);
        n_cmp++;
        if (o !== 8'h00) begin n_bad++; $display("FAIL reset_release got %h want 00", o); end
    endtask

    task automatic test_read(input string nm);
        logic [11:0] v [5] = '{12'hE00, 12'hA90, 12'hB8E, 12'hAC0, 12'hA00};
        mdatain = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            step(v[i][11:8]);
            n_cmp++;
            if (o !== v[i][7:0]) begin n_bad++; $display("FAIL %s c%0d got %h want %h", nm, i, o, v[i][7:0]); end
        end
        n_cmp++;
        if (mdr !== 32'hDEADBEEF) begin n_bad++; $display("FAIL %s_mdr got %h want deadbeef", nm, mdr); end
    endtask

    task automatic test_write;
        logic [11:0] v [9] = '{12'hC00, 12'h890, 12'h888, 12'h881, 12'h881, 12'h881, 12'h981, 12'h8C0, 12'h800};
        mdatain = 32'hCAFEF00D;
        for (int i = 0; i < 9; i++) begin
            step(v[i][11:8]);
            n_cmp++;
            if (o !== v[i][7:0]) begin n_bad++; $display("FAIL write c%0d got %h want %h", i, o, v[i][7:0]); end
        end
        n_cmp++;
        if (mdr !== 32'h12345678) begin n_bad++; $display("FAIL write_mdr got %h want 12345678", mdr); end
    endtask

    task automatic test_timeout;
        logic [11:0] v [8] = '{12'hE00, 12'hA90, 12'hA86, 12'hA86, 12'hA86, 12'hA86, 12'hAA0, 12'hA00};
        mdatain = 32'h55AA55AA;
        for (int i = 0; i < 8; i++) begin
            step(v[i][11:8]);
            n_cmp++;
            if (o !== v[i][7:0]) begin n_bad++; $display("FAIL timeout c%0d got %h want %h", i, o, v[i][7:0]); end
        end
        n_cmp++;
        if (mdr !== 32'h12345678) begin n_bad++; $display("FAIL timeout_mdr got %h want 12345678", mdr); end
    endtask

    task automatic test_coincide;
        logic [11:0] v [8] = '{12'hE00, 12'hA90, 12'hA86, 12'hA86, 12'hA86, 12'hB8E, 12'hAC0, 12'hA00};
        mdatain = 32'h0000BEEF;
        for (int i = 0; i < 8; i++) begin
            step(v[i][11:8]);
            n_cmp++;
            if (o !== v[i][7:0]) begin n_bad++; $display("FAIL coincide c%0d got %h want %h", i, o, v[i][7:0]); end
        end
        n_cmp++;
        if (mdr !== 32'h0000BEEF) begin n_bad++; $display("FAIL coincide_mdr got %h want 0000beef", mdr); end
    endtask

    task automatic test_reset_mid;
        logic [11:0] v [8] = '{12'hC00, 12'h890, 12'h888, 12'h881, 12'h081, 12'h900, 12'h800, 12'h800};
        for (int i = 0; i < 8; i++) begin
            step(v[i][11:8]);
            n_cmp++;
            if (o !== v[i][7:0]) begin n_bad++; $display("FAIL reset_mid c%0d got %h want %h", i, o, v[i][7:0]); end
        end
    endtask

    task automatic test_start_ignore;
        logic [11:0] v [10] = '{12'hE00, 12'hC90, 12'hC86, 12'hB8E, 12'hCC0,
                                12'hE00, 12'hA90, 12'hB8E, 12'hAC0, 12'hA00};
        mdatain = 32'h0BADF00D;
        for (int i = 0; i < 10; i++) begin
            step(v[i][11:8]);
            n_cmp++;
            if (o !== v[i][7:0]) begin n_bad++; $display("FAIL start_ignore c%0d got %h want %h", i, o, v[i][7:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_read("read");
        test_write();
        test_timeout();
        test_coincide();
        test_reset_mid();
        test_read("read_after_reset");
        test_start_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
